// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and store-width masks.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment of store enables/data plus misalignment detect.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic        we,
  input  logic [3:0]  mask,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_aligned,
  output logic        misalign
);

  // Enables past lane 3 fall off the top; misaligned requests keep only the in-word lanes.
  assign be            = we ? 4'(mask << addr_lo) : 4'b1111;
  assign wdata_aligned = wdata << {addr_lo, 3'b000};
  assign misalign      = ((mask == MASK_WORD) && (addr_lo != 2'b00)) ||
                         ((mask == MASK_HALF) && addr_lo[0]);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for one synchronous memory port, data priority with starvation guard.
// Optional MEM_PORT_ARB_MISALIGN_EN: misaligned data requests complete at once with d_err.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] STREAK_MAX = '1;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             grant_f, grant_d;
  logic             skip;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic             misalign;

  mem_lane_align u_align (
    .we            (d_we),
    .mask          (d_mask),
    .addr_lo       (d_addr[1:0]),
    .wdata         (d_wdata),
    .be            (al_be),
    .wdata_aligned (al_wdata),
    .misalign      (misalign)
  );

`ifdef MEM_PORT_ARB_MISALIGN_EN
  logic d_err_q;
  logic unused_bits;
  assign skip        = misalign;
  assign d_err       = d_err_q;
  assign unused_bits = ^if_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_err_q <= 1'b0;
    else        d_err_q <= grant_d && skip;
  end
`else
  logic unused_bits;
  assign skip        = 1'b0;
  assign d_err       = 1'b0;
  assign unused_bits = ^{if_addr[1:0], misalign};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    streak_d = streak_q;
    grant_f  = 1'b0;
    grant_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_req && (!if_req || (streak_q < LIMIT))) begin
          grant_d = 1'b1;
          state_d = skip ? ARB_RESP : ARB_DATA;
          // The streak only counts data grants that made a pending fetch wait.
          if (!if_req)                  streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + CNT_W'(1);
        end else if (if_req) begin
          grant_f  = 1'b1;
          state_d  = ARB_FETCH;
          streak_d = '0;
        end else begin
          streak_d = '0;
        end
      end
      ARB_FETCH, ARB_DATA: if (mem_ack) state_d = ARB_RESP;
      ARB_RESP:            state_d = ARB_IDLE;
      default:             state_d = ARB_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignment; every register, including the
  // captured read data, is cleared by the async reset so an aborted access leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      streak_q  <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;

      if (grant_f) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= {if_addr[31:2], 2'b00};
        mem_be    <= 4'b1111;
        mem_wdata <= '0;
      end else if (grant_d) begin
        if (skip) begin
          d_ack <= 1'b1;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= d_we;
          mem_addr  <= {d_addr[31:2], 2'b00};
          mem_be    <= al_be;
          mem_wdata <= al_wdata;
        end
      end

      if (mem_ack && ((state_q == ARB_FETCH) || (state_q == ARB_DATA))) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (state_q == ARB_FETCH) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end else begin
          d_rdata <= mem_rdata;
          d_ack   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between the instruction-fetch requester and the load/store requester.
- The load/store requester is driven by the decoder's mem_read, mem_write and mem_mask controls.
- Sequences each access as a registered req/ack transaction.
- Aligns store byte-enables and write data to the addressed byte lanes.
- Enforces data-over-fetch priority with a starvation guard so fetch always progresses.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while fetch is pending before fetch is forced (1..15)
CNT_W, 4, width of the data-streak counter; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_ack
if_addr  in  32  fetch byte address; word-aligned, stable while if_req
if_ack  out  1  one-cycle pulse, fetch complete
if_rdata  out  32  fetch data; valid when if_ack
d_req  in  1  load/store request; held until d_ack
d_we  in  1  1 = store, 0 = load (lw)
d_mask  in  4  0001 byte, 0011 half, 1111 word (store width)
d_addr  in  32  data byte address; stable while d_req
d_wdata  in  32  store data, right-justified
d_ack  out  1  one-cycle pulse, load/store complete
d_rdata  out  32  load data, raw word; valid when d_ack
d_err  out  1  misalignment error; valid with d_ack (see Optional Feature)
mem_req  out  1  memory request, registered, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_be  out  4  byte-lane enables
mem_wdata  out  32  lane-aligned write data
mem_ack  in  1  memory completes the access this cycle
mem_rdata  in  32  read data; valid with mem_ack

Clock and reset (already decided):
- One clock, clk.
- Reset rst_n is asynchronous, active-low.

Behaviour:
- Reset: state=IDLE. if_ack, d_ack, d_err, mem_req and mem_we are 0. mem_addr, mem_be, mem_wdata, if_rdata, d_rdata and streak counter are 0.
- Reset asserted mid-transaction aborts immediately: mem_req drops asynchronously and no ack is issued.

State machine (IDLE, FETCH, DATA, RESP):
- IDLE:
  - If d_req and (!if_req or streak<STARVE_LIMIT): go to DATA and streak++ (saturating).
  - Else if if_req: go to FETCH and streak=0.
  - Memory outputs are registered on the transition, so mem_req rises on the first cycle of FETCH/DATA.
- FETCH/DATA: hold mem_req and all memory outputs stable until mem_ack=1. On mem_ack, capture mem_rdata into if_rdata/d_rdata, drop mem_req and go to RESP.
- RESP (exactly one cycle):
  - Pulse the owning ack (if_ack or d_ack), then go to IDLE.
  - No arbitration in RESP, so a requester may drop or change its request at the edge after its ack.
- Streak counter resets to 0 whenever fetch is granted, or whenever IDLE sees no if_req.

Latency:
- Minimum: request sampled at edge 0, mem_req in cycle 1, mem_ack in cycle 1, ack in cycle 2.
- Total = 2 + memory wait cycles.

Lane alignment (d_we=1):
- mem_be = (d_mask << d_addr[1:0]) truncated to 4 bits.
- mem_wdata = d_wdata << (8*d_addr[1:0]).
- Loads: mem_be=1111, mem_we=0.
- Fetch: mem_be=1111, mem_we=0, mem_wdata=0.

Protocol rules:
- A requester dropping its req mid-transaction does not cancel it: the memory access completes and the ack still pulses.
- mem_ack outside FETCH/DATA is ignored.
- if_rdata and d_rdata hold their value until the next capture.

Optional Feature:
Macro: MEM_PORT_ARB_MISALIGN_EN
- Defined: a data request is misaligned if (d_mask==1111 and d_addr[1:0]!=0) or (d_mask==0011 and d_addr[0]!=0). When IDLE grants a misaligned request:
  - Go directly to RESP with no mem_req.
  - d_ack=1, d_err=1; d_rdata is unchanged.
  - Counts as a data grant for the streak counter.
- Undefined: d_err is tied 0. Misaligned accesses proceed with truncated enables, e.g. mask 0011 at addr[1:0]=3 gives mem_be=1000.

Decomposition:
- Shared package header (alongside the ALU op defines) holds:
  - state encodings ARB_IDLE/ARB_FETCH/ARB_DATA/ARB_RESP;
  - mask constants MASK_BYTE=0001, MASK_HALF=0011, MASK_WORD=1111.
- One sub-module, mem_lane_align: purely combinational mask/data shift plus misalign detect, instantiated once.
- FSM, counter and registers stay in mem_port_arbiter.

Test Plan:
- Fetch only, if_addr=0x100, mem_ack on first mem_req cycle, mem_rdata=0x2000_0001:
  - mem_addr=0x100, mem_be=1111;
  - if_ack on cycle 2 with if_rdata=0x2000_0001.
- Store byte, d_addr=0x203, d_wdata=0x0000_00AB, d_mask=0001:
  - mem_addr=0x200, mem_be=1000, mem_wdata=0xAB00_0000, mem_we=1.
- if_req and d_req held continuously, STARVE_LIMIT=4, single-cycle memory:
  - grant order D,D,D,D,F,D,D,D,D,F.
- Memory stalls 5 cycles on a load:
  - mem_req and mem_addr stable all 5 cycles, exactly one d_ack.
  - if_req asserted meanwhile is granted only after RESP.
- rst_n low in cycle 2 of a DATA transaction:
  - mem_req=0 immediately, no d_ack;
  - after release, the still-pending request restarts from IDLE.
- With MEM_PORT_ARB_MISALIGN_EN, word store to 0x102:
  - no mem_req, d_ack=1 and d_err=1 on the cycle after the grant.
- Without the macro, the same stimulus gives mem_be=1100, d_err=0.
